// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state encoding and default geometry for the register file
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NREAD = 2;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequential clear engine: sweeps every entry to zero after reset or on request
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          cclk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          busy,
  output logic          done,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          done_nxt;

  always_ff @(posedge cclk) begin
    if (rst) begin
      state <= SWEEP;
      ptr   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt = SWEEP;
          ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          ptr_nxt = ptr + AW'(1);
        end
      end
    endcase
  end

  assign busy       = (state == SWEEP);
  // A reset edge only restarts the sweep; it must not also clear an entry.
  assign sweep_we   = busy && !rst;
  assign sweep_addr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised two-write, NREAD-read register file with clear sweep
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int NREAD    = DEF_NREAD,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   cclk,
  input  logic                   rst,
  input  logic                   write0,
  input  logic [AW-1:0]          write_reg0,
  input  logic [WIDTH-1:0]       write_data0,
  input  logic                   write1,
  input  logic [AW-1:0]          write_reg1,
  input  logic [WIDTH-1:0]       write_data1,
  input  logic [NREAD*AW-1:0]    read_reg,
  output logic [NREAD*WIDTH-1:0] read_data,
  input  logic                   clear_req,
  output logic                   busy,
  output logic                   done
);

  localparam logic [AW:0] DEPTH_A = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             sweep_we;
  logic [AW-1:0]    sweep_addr;
  logic             wr_ok0, wr_ok1;

  // An address is usable if it lies inside the array and is not the hardwired zero entry.
  function automatic logic legal(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_A) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  regfile_clear_fsm #(.DEPTH(DEPTH)) u_clear (
    .cclk      (cclk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .done      (done),
    .sweep_we  (sweep_we),
    .sweep_addr(sweep_addr)
  );

  assign wr_ok0 = write0 && !busy && !clear_req && !rst && legal(write_reg0);
  assign wr_ok1 = write1 && !busy && !clear_req && !rst && legal(write_reg1);

  // Port 1 is applied last so it wins an address collision.
  always_ff @(posedge cclk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else begin
      if (wr_ok0) mem[write_reg0] <= write_data0;
      if (wr_ok1) mem[write_reg1] <= write_data1;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;

    assign ra = read_reg[k*AW +: AW];

    always_comb begin
      rd = '0;
      if (!busy && legal(ra)) begin
        rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok1 && (write_reg1 == ra)) begin
          rd = write_data1;
        end else if (wr_ok0 && (write_reg0 == ra)) begin
          rd = write_data0;
        end
`endif
      end
    end

    assign read_data[k*WIDTH +: WIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (odd geometry, randomized traffic)
module tb_regfile_mp;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 24;
  localparam int NREAD    = 3;
  localparam int ZERO_REG = 1;
  localparam int AW       = $clog2(DEPTH);
  localparam int AMAX     = (1 << AW) - 1;

  logic                   cclk = 1'b0;
  logic                   rst = 1'b0;
  logic                   write0 = 1'b0, write1 = 1'b0, clear_req = 1'b0;
  logic [AW-1:0]          write_reg0 = '0, write_reg1 = '0;
  logic [WIDTH-1:0]       write_data0 = '0, write_data1 = '0;
  logic [NREAD*AW-1:0]    read_reg = '0;
  logic [NREAD*WIDTH-1:0] read_data;
  logic                   busy, done;

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .ZERO_REG(ZERO_REG)) dut (
    .cclk       (cclk),
    .rst        (rst),
    .write0     (write0),
    .write_reg0 (write_reg0),
    .write_data0(write_data0),
    .write1     (write1),
    .write_reg1 (write_reg1),
    .write_data1(write_data1),
    .read_reg   (read_reg),
    .read_data  (read_data),
    .clear_req  (clear_req),
    .busy       (busy),
    .done       (done)
  );

  always #5 cclk = ~cclk;

  typedef struct packed {
    logic                   busy;
    logic                   done;
    logic [NREAD*WIDTH-1:0] rd;
    int                     cyc;
  } exp_t;

  exp_t             q[$];
  exp_t             mon_e;
  int               checks = 0;
  int               errors = 0;

  // Reference model: sweep is a countdown of remaining edges; contents are zeroed when a sweep starts
  int               ra[NREAD];
  logic [WIDTH-1:0] mem_m[DEPTH];
  int               sweep_left = 0;
  logic             done_m = 1'b0;
  bit               model_ok = 1'b0;
  int               cyc = 0;

  function automatic logic [WIDTH-1:0] exp_read(input int a);
    if (sweep_left > 0 || a >= DEPTH || (ZERO_REG != 0 && a == 0)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && !clear_req && write1 && int'(write_reg1) == a) return write_data1;
    if (!rst && !clear_req && write0 && int'(write_reg0) == a) return write_data0;
`endif
    return mem_m[a];
  endfunction

  task automatic model_write(input logic we, input int a, input logic [WIDTH-1:0] d);
    if (we && a < DEPTH && !(ZERO_REG != 0 && a == 0)) mem_m[a] = d;
  endtask

  task automatic step(input logic r, input logic c,
                      input logic w0, input int a0, input logic [WIDTH-1:0] d0,
                      input logic w1, input int a1, input logic [WIDTH-1:0] d1);
    exp_t e;
    rst = r; clear_req = c;
    write0 = w0; write_reg0 = AW'(a0); write_data0 = d0;
    write1 = w1; write_reg1 = AW'(a1); write_data1 = d1;
    for (int k = 0; k < NREAD; k++) read_reg[k*AW +: AW] = AW'(ra[k]);
    if (model_ok) begin
      e.busy = (sweep_left > 0);
      e.done = done_m;
      for (int k = 0; k < NREAD; k++) e.rd[k*WIDTH +: WIDTH] = exp_read(ra[k]);
      e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge cclk);
    if (r) begin
      sweep_left = DEPTH;
      done_m = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end else if (sweep_left > 0) begin
      sweep_left--;
      done_m = (sweep_left == 0);
    end else begin
      done_m = 1'b0;
      if (c) begin
        sweep_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      end else begin
        model_write(w0, a0, d0);
        model_write(w1, a1, d1);
      end
    end
    model_ok = model_ok | r;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic rand_ra();
    for (int k = 0; k < NREAD; k++) ra[k] = $urandom_range(0, AMAX);
  endtask

  always @(negedge cclk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      checks++;
      if (busy !== mon_e.busy) begin
        errors++;
        $display("FAIL busy cyc %0d got %b exp %b", mon_e.cyc, busy, mon_e.busy);
      end
      checks++;
      if (done !== mon_e.done) begin
        errors++;
        $display("FAIL done cyc %0d got %b exp %b", mon_e.cyc, done, mon_e.done);
      end
      for (int k = 0; k < NREAD; k++) begin
        checks++;
        if (read_data[k*WIDTH +: WIDTH] !== mon_e.rd[k*WIDTH +: WIDTH]) begin
          errors++;
          $display("FAIL read%0d cyc %0d addr %0d got %h exp %h", k, mon_e.cyc,
                   read_reg[k*AW +: AW], read_data[k*WIDTH +: WIDTH], mon_e.rd[k*WIDTH +: WIDTH]);
        end
      end
    end
  end

  initial begin
    int a, b;
    @(posedge cclk); #1;

    // reset then full sweep, reads across the space including out-of-range
    rand_ra();
    step(1, 0, 0, 0, '0, 0, 0, '0);
    for (int i = 0; i < DEPTH + 3; i++) begin rand_ra(); idle(1); end

    // collision on reg 5: port 1 wins
    ra[0] = 5; ra[1] = 5; ra[2] = 30;
    step(0, 0, 1, 5, 32'hAAAA0000, 1, 5, 32'h0000BBBB);
    idle(1);

    // hardwired zero entry
    ra[0] = 0; ra[1] = 0; ra[2] = 5;
    step(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, '0);
    idle(1);

    // same-cycle write/read of reg 7
    ra[0] = 7; ra[1] = 7; ra[2] = 0;
    step(0, 0, 1, 7, 32'h12345678, 0, 0, '0);
    idle(1);

    // load, then clear with a colliding write, then a second clear mid-sweep
    for (int i = 1; i < DEPTH; i++) begin
      ra[0] = i; ra[1] = i - 1; ra[2] = 3;
      step(0, 0, 1, i, $urandom | 32'h1, 0, 0, '0);
    end
    ra[0] = 3;
    step(0, 1, 1, 3, 32'hDEADBEEF, 0, 0, '0);
    idle(5);
    step(0, 1, 0, 0, '0, 1, 4, 32'h5555AAAA);
    idle(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      ra[0] = i; ra[1] = DEPTH - 1 - i; ra[2] = 30;
      idle(1);
    end

    // reset during a sweep restarts it
    step(0, 1, 0, 0, '0, 0, 0, '0);
    idle(9);
    step(1, 0, 0, 0, '0, 0, 0, '0);
    idle(DEPTH + 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, AMAX);
      b = ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, AMAX);
      for (int k = 0; k < NREAD; k++)
        ra[k] = ($urandom_range(0, 2) == 0) ? b : $urandom_range(0, AMAX);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0,
           1'($urandom_range(0, 1)), a, $urandom,
           1'($urandom_range(0, 1)), b, $urandom);
    end

    @(negedge cclk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
